// File: rtl/apb_pkg.sv
// Shared APB types and response codes for the APB slaves in this subsystem.
// The sibling error and default slaves reuse the state enum defined here.
package apb_pkg;

    localparam int unsigned APB_AW = 32;
    localparam int unsigned APB_DW = 32;
    localparam int unsigned APB_SW = APB_DW / 8;

    localparam logic RESP_OKAY   = 1'b0;
    localparam logic RESP_SLVERR = 1'b1;

    typedef struct packed {
        logic              psel;
        logic              penable;
        logic              pwrite;
        logic [APB_AW-1:0] paddr;
        logic [APB_DW-1:0] pwdata;
        logic [APB_SW-1:0] pstrb;
    } apb_req_t;

    typedef struct packed {
        logic [APB_DW-1:0] prdata;
        logic              pready;
        logic              pslverr;
    } apb_resp_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } apb_err_state_e;

endpackage

// File: rtl/sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Clear and increment in the same cycle leave the counter at one.
module sat_cnt #(
    parameter int unsigned Width = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [Width-1:0] o_cnt
);

    logic [Width-1:0] r_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= i_inc ? Width'(1) : '0;
        end else if (i_inc && (r_cnt != '1)) begin
            r_cnt <= r_cnt + Width'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/apb_err_slv_seq.sv
// Sequential APB error/default slave: terminates every transfer after a fixed
// number of wait states and logs the first offending transfer since clear.
//
// state  | meaning
// IDLE   | no transfer in flight, waiting for a setup phase
// ACCESS | setup seen; counting wait states down to completion
module apb_err_slv_seq
    import apb_pkg::*;
#(
    parameter type                   req_t         = apb_req_t,
    parameter type                   resp_t        = apb_resp_t,
    parameter int unsigned           RespWidth     = 32,
    parameter logic [RespWidth-1:0]  RespData      = 32'hBADCAB1E,
    parameter int unsigned           NumWaitStates = 0,
    parameter logic                  RespError     = 1'b1,
    parameter int unsigned           AddrWidth     = 32,
    parameter int unsigned           CntWidth      = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  req_t                 slv_req_i,
    output resp_t                slv_resp_o,
    input  logic                 clr_i,
    output logic                 err_valid_o,
    output logic [AddrWidth-1:0] err_addr_o,
    output logic                 err_write_o,
    output logic [CntWidth-1:0]  err_cnt_o
);

    localparam int unsigned DataW   = $bits(slv_resp_o.prdata);
    localparam int unsigned PaddrW  = $bits(slv_req_i.paddr);
    localparam logic [7:0]  WaitLd  = 8'(NumWaitStates);

    apb_err_state_e r_state, w_state_nxt;
    logic [7:0]     r_wcnt, w_wcnt_nxt;
    logic           w_done;
    logic [DataW-1:0]     w_rdata;
    logic [AddrWidth-1:0] w_addr;
    logic                 r_err_valid, r_err_write;
    logic [AddrWidth-1:0] r_err_addr;
    logic                 w_unused_req;

    if (RespWidth >= DataW) begin : g_rd_trunc
        assign w_rdata = RespData[DataW-1:0];
    end else begin : g_rd_ext
        assign w_rdata = {{(DataW-RespWidth){1'b0}}, RespData};
    end

    if (AddrWidth <= PaddrW) begin : g_ad_trunc
        assign w_addr = slv_req_i.paddr[AddrWidth-1:0];
    end else begin : g_ad_ext
        assign w_addr = {{(AddrWidth-PaddrW){1'b0}}, slv_req_i.paddr};
    end

    // Write data and strobes carry no meaning for a terminating slave.
    assign w_unused_req = ^slv_req_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
            r_wcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_wcnt  <= w_wcnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wcnt_nxt  = r_wcnt;
        case (r_state)
            IDLE: begin
                if (slv_req_i.psel && !slv_req_i.penable) begin
                    w_state_nxt = ACCESS;
                    w_wcnt_nxt  = WaitLd;
                end
            end
            ACCESS: begin
                if (!slv_req_i.psel) begin
                    w_state_nxt = IDLE;
                end else if (!slv_req_i.penable) begin
                    w_wcnt_nxt = WaitLd;
                end else if (r_wcnt != 8'd0) begin
                    w_wcnt_nxt = r_wcnt - 8'd1;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_done = (r_state == ACCESS) && slv_req_i.psel && slv_req_i.penable
                 && (r_wcnt == 8'd0);
        slv_resp_o         = '0;
        slv_resp_o.pready  = w_done;
        slv_resp_o.pslverr = w_done ? (RespError ? RESP_SLVERR : RESP_OKAY) : 1'b0;
        slv_resp_o.prdata  = (w_done && !slv_req_i.pwrite) ? w_rdata : '0;
    end

    // A clear coinciding with a completion re-arms the log with that transfer.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_err_valid <= 1'b0;
            r_err_addr  <= '0;
            r_err_write <= 1'b0;
        end else if (w_done && (!r_err_valid || clr_i)) begin
            r_err_valid <= 1'b1;
            r_err_addr  <= w_addr;
            r_err_write <= slv_req_i.pwrite;
        end else if (clr_i) begin
            r_err_valid <= 1'b0;
        end
    end

    sat_cnt #(
        .Width (CntWidth)
    ) u_err_cnt (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .i_clr (clr_i),
        .i_inc (w_done),
        .o_cnt (err_cnt_o)
    );

    assign err_valid_o = r_err_valid;
    assign err_addr_o  = r_err_addr;
    assign err_write_o = r_err_write;

endmodule

// File: doc/apb_err_slv_seq.md
Name: apb_err_slv_seq

Overview:
Parametrised sequential APB error slave, the successor to the combinational error slave. It terminates every APB transfer routed to an unmapped or disabled region and inserts a configurable number of wait states. Response code is selectable: SLVERR, or OKAY for use as a default slave. It logs the first offending address and keeps a saturating count of terminated transfers, which a debug/CSR block reads and clears.

Parameters:
req_t, logic, APB request struct (psel, penable, pwrite, paddr, pwdata, pstrb)
resp_t, logic, APB response struct (prdata, pready, pslverr)
RespWidth, 32, width of RespData; zero-extended or truncated to prdata width
RespData, 32'hBADCAB1E, read data returned on every terminated transfer
NumWaitStates, 0, wait cycles in access phase before pready (0..255)
RespError, 1'b1, 1: pslverr=apb_pkg::RESP_SLVERR; 0: apb_pkg::RESP_OKAY
AddrWidth, 32, width of logged address; paddr zero-extended or truncated
CntWidth, 16, width of saturating transfer counter

Ports:
clk_i  input  1  clock, all logic on rising edge
rst_i  input  1  synchronous active-high reset
slv_req_i  input  req_t  APB request from interconnect
slv_resp_o  output  resp_t  APB response
clr_i  input  1  single-cycle pulse; clears err_cnt_o and err_valid_o
err_valid_o  output  1  sticky; a logged transfer is held in err_addr_o/err_write_o
err_addr_o  output  AddrWidth  paddr of first logged transfer since clear
err_write_o  output  1  pwrite of first logged transfer
err_cnt_o  output  CntWidth  terminated transfers since clear, saturating

Behaviour:
- FSM states: IDLE, ACCESS. Wait counter wcnt is 8 bits.
- IDLE: on psel & !penable (setup phase), load wcnt=NumWaitStates and go to ACCESS. Otherwise stay.
- ACCESS, psel & penable:
  - wcnt!=0: decrement wcnt.
  - wcnt==0: transfer completes this cycle; next state IDLE.
- ACCESS, psel low: protocol abort. Return to IDLE; no completion, no logging.
- ACCESS, psel & !penable: treat as a new setup. Reload wcnt and stay in ACCESS.
- pready = (state==ACCESS) & psel & penable & (wcnt==0). It is combinational from registered state and current inputs.
- Latency: completion occurs NumWaitStates+1 cycles after the setup cycle. Total transfer is NumWaitStates+2 cycles.
- pslverr = pready ? (RespError ? RESP_SLVERR : RESP_OKAY) : 0.
- prdata = RespData (width-adjusted) when pready & !pwrite, else 0.
- Back-to-back: a setup in the cycle after completion is accepted normally (IDLE path).
- Completion event done = pready:
  - err_cnt_o increments and saturates at all-ones. It counts reads and writes and is independent of RespError.
  - If err_valid_o==0: capture paddr into err_addr_o and pwrite into err_write_o, and set err_valid_o. A later done does not overwrite them.
- clr_i alone: err_cnt_o=0, err_valid_o=0. err_addr_o and err_write_o keep their values.
- clr_i with done in the same cycle: err_cnt_o=1, err_valid_o=1, and the capture uses the current transfer.
- Reset values: state IDLE, wcnt 0, err_cnt_o 0, err_valid_o 0, err_addr_o 0, err_write_o 0.
- All slv_resp_o fields are 0 during and after reset until a transfer completes.
- rst_i asserted mid-transfer: the FSM returns to IDLE. The in-flight transfer is dropped and not logged. The master must restart it.
- pwdata and pstrb are ignored.

Decomposition:
- apb_pkg (existing shared package): RESP_OKAY/RESP_SLVERR already live here. Add apb_err_state_e (IDLE, ACCESS) so the sibling error/default slaves share it.
- Sub-module sat_cnt #(Width): synchronous clear, increment, saturation. Clear and increment together yield 1. It is used for err_cnt_o and is reusable by other monitors.
- The FSM and wait counter stay in the top module.

Test Plan:
- NumWaitStates=0, RespError=1, read at paddr 0x4000_0010 -> pready in 2nd cycle, pslverr=1, prdata=0xBADCAB1E, err_valid_o=1, err_addr_o=0x4000_0010, err_cnt_o=1.
- NumWaitStates=3, write at 0x100 -> pready low for 3 access cycles then high in cycle 5, prdata=0, err_write_o=1.
- Three back-to-back reads at 0x10, 0x20, 0x30 -> err_cnt_o=3, err_addr_o stays 0x10; clr_i pulse -> err_cnt_o=0, err_valid_o=0; next transfer at 0x40 -> err_addr_o=0x40.
- clr_i coincident with completion at 0x80 -> err_cnt_o=1, err_valid_o=1, err_addr_o=0x80.
- CntWidth=2, 5 transfers -> err_cnt_o saturates at 3; RespError=0 -> pslverr=0 with prdata=RespData.
- NumWaitStates=4: psel drops after 2 access cycles -> no pready, no logging. Separately, rst_i asserted in ACCESS -> outputs 0, state IDLE, and a new transfer completes correctly.
